// File: rtl/disp_scroll_ctrl.sv
// Scroll sequencer feeding the four digit patterns of disp_mux from a message buffer.
// Optional macro DISP_SCROLL_PAUSE_EN adds a `pause` input that freezes scrolling.
module disp_scroll_ctrl #(
  parameter int         TICK_DIV = 25_000_000,
  parameter int         DEPTH    = 16,
  parameter logic [7:0] BLANK    = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   clr,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop,
`ifdef DISP_SCROLL_PAUSE_EN
  input  logic                   pause,
`endif
  output logic [7:0]             in0,
  output logic [7:0]             in1,
  output logic [7:0]             in2,
  output logic [7:0]             in3,
  output logic [$clog2(DEPTH):0] len,
  output logic                   full,
  output logic                   busy,
  output logic                   done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [LW-1:0] LEN_FULL  = LW'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FEED = 2'd1, ST_FLUSH = 2'd2} state_t;

  state_t          state_r, state_s;
  logic [LW-1:0]   len_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   tick_r;
  logic [1:0]      flush_r;
  logic [7:0]      buf_r [DEPTH];
  logic [7:0]      in0_r, in1_r, in2_r, in3_r;
  logic            busy_r, done_r;

  logic            idle_s, run_s, pause_s, halt_s;
  logic            wr_ok_s, start_ok_s, step_s;
  logic            last_feed_s, last_flush_s, done_s;
  logic [LW-1:0]   len_post_s;
  logic [7:0]      src_s;

`ifdef DISP_SCROLL_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  // Command qualification and step decode
  always_comb begin
    idle_s       = (state_r == ST_IDLE);
    run_s        = !idle_s;
    halt_s       = run_s && stop;
    wr_ok_s      = idle_s && wr_en && !clr && (len_r != LEN_FULL);
    len_post_s   = wr_ok_s ? (len_r + LW'(1)) : len_r;
    start_ok_s   = idle_s && start && !clr && (len_post_s != {LW{1'b0}});
    step_s       = run_s && !stop && !pause_s && (tick_r == TICK_LAST);
    last_feed_s  = (state_r == ST_FEED) && ({1'b0, rd_ptr_r} == (len_r - LW'(1)));
    last_flush_s = (state_r == ST_FLUSH) && (flush_r == 2'd3);
    src_s        = (state_r == ST_FEED) ? buf_r[rd_ptr_r] : BLANK;
    done_s       = step_s && last_flush_s && !loop;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) state_s = ST_FEED;
        else            state_s = ST_IDLE;
      end
      ST_FEED: begin
        if (stop)                       state_s = ST_IDLE;
        else if (step_s && last_feed_s) state_s = ST_FLUSH;
        else                            state_s = ST_FEED;
      end
      ST_FLUSH: begin
        if (stop)                        state_s = ST_IDLE;
        else if (step_s && last_flush_s) state_s = loop ? ST_FEED : ST_IDLE;
        else                             state_s = ST_FLUSH;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Message storage; contents need no reset
  always_ff @(posedge clk) begin
    if (wr_ok_s) buf_r[len_r[AW-1:0]] <= wr_data;
  end

  // Control state, step timing and the digit shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      len_r    <= {LW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      tick_r   <= {CW{1'b0}};
      flush_r  <= 2'd0;
      in0_r    <= BLANK;
      in1_r    <= BLANK;
      in2_r    <= BLANK;
      in3_r    <= BLANK;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= done_s;

      if (idle_s && clr)  len_r <= {LW{1'b0}};
      else if (wr_ok_s)   len_r <= len_r + LW'(1);

      if (start_ok_s || halt_s) begin
        tick_r   <= {CW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
        flush_r  <= 2'd0;
      end else if (run_s && !pause_s) begin
        tick_r <= (tick_r == TICK_LAST) ? {CW{1'b0}} : (tick_r + CW'(1));
        if (step_s) begin
          // Leaving FEED or restarting from FLUSH both rewind the read pointer
          if (state_r == ST_FEED) begin
            rd_ptr_r <= last_feed_s ? {AW{1'b0}} : (rd_ptr_r + AW'(1));
            flush_r  <= 2'd0;
          end else begin
            rd_ptr_r <= {AW{1'b0}};
            flush_r  <= flush_r + 2'd1;
          end
        end
      end

      if (idle_s && clr) begin
        in0_r <= BLANK;
        in1_r <= BLANK;
        in2_r <= BLANK;
        in3_r <= BLANK;
      end else if (step_s) begin
        in3_r <= in2_r;
        in2_r <= in1_r;
        in1_r <= in0_r;
        in0_r <= src_s;
      end
    end
  end

  assign in0  = in0_r;
  assign in1  = in1_r;
  assign in2  = in2_r;
  assign in3  = in3_r;
  assign len  = len_r;
  assign full = (len_r == LEN_FULL);
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_disp_scroll_ctrl.sv
// Bench for disp_scroll_ctrl: directed plan plus random stimulus against a message/stream model.
module tb_disp_scroll_ctrl;
  localparam int TICK  = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset, wr_en, clr, start, stop, loop;
  logic [7:0] wr_data;
  logic [7:0] in0, in1, in2, in3;
  logic [3:0] len;
  logic       full, busy, done;

  int total = 0;
  int bad   = 0;

  // Model: stored message, displayed digits (index 0 = in0), scroll position in msg+4 blanks
  logic [7:0] msg [$];
  logic [7:0] m_disp [4];
  bit         m_run, m_done, m_valid;
  int         m_pos, m_elapsed;

  disp_scroll_ctrl #(.TICK_DIV(TICK), .DEPTH(DEPTH), .BLANK(8'hFF)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .clr(clr),
    .start(start), .stop(stop), .loop(loop),
`ifdef DISP_SCROLL_PAUSE_EN
    .pause(1'b0),
`endif
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .len(len), .full(full), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [7:0] src;
    m_done = 1'b0;
    if (reset) begin
      msg.delete();
      for (int i = 0; i < 4; i++) m_disp[i] = 8'hFF;
      m_run = 1'b0;
    end else if (!m_run) begin
      if (clr) begin
        msg.delete();
        for (int i = 0; i < 4; i++) m_disp[i] = 8'hFF;
      end else begin
        if (wr_en && msg.size() < DEPTH) msg.push_back(wr_data);
        if (start && msg.size() > 0) begin
          m_run = 1'b1; m_elapsed = 0; m_pos = 0;
        end
      end
    end else if (stop) begin
      m_run = 1'b0;
    end else begin
      if (m_elapsed % TICK == TICK - 1) begin
        src = (m_pos < msg.size()) ? msg[m_pos] : 8'hFF;
        m_disp[3] = m_disp[2]; m_disp[2] = m_disp[1];
        m_disp[1] = m_disp[0]; m_disp[0] = src;
        m_pos++;
        if (m_pos == msg.size() + 4) begin
          if (loop) m_pos = 0;
          else begin m_run = 1'b0; m_done = 1'b1; end
        end
      end
      m_elapsed++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic idle_in();
    wr_en = 1'b0; wr_data = 8'h00; clr = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("in0", 32'(in0), 32'(m_disp[0]));
      chk("in1", 32'(in1), 32'(m_disp[1]));
      chk("in2", 32'(in2), 32'(m_disp[2]));
      chk("in3", 32'(in3), 32'(m_disp[3]));
      chk("len", 32'(len), 32'(msg.size()));
      chk("full", 32'(full), 32'(msg.size() == DEPTH));
      chk("busy", 32'(busy), 32'(m_run));
      chk("done", 32'(done), 32'(m_done));
    end
  end

  initial begin
    m_valid = 1'b0;
    reset = 1'b1;
    idle_in();
    tick();
    m_valid = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("rst_in0", 32'(in0), 32'hFF);
    chk("rst_in3", 32'(in3), 32'hFF);
    chk("rst_len", 32'(len), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("empty_start", 32'(busy), 32'd0);

    // Three-entry single pass
    wr_en = 1'b1;
    wr_data = 8'hA1; tick();
    wr_data = 8'hB2; tick();
    wr_data = 8'hC3; tick();
    wr_en = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    chk("pre_step1", 32'(in0), 32'hFF);
    tick();
    chk("step1_in0", 32'(in0), 32'hA1);
    repeat (8) tick();
    chk("step3_in2", 32'(in2), 32'hA1);
    chk("step3_in1", 32'(in1), 32'hB2);
    chk("step3_in0", 32'(in0), 32'hC3);
    repeat (15) tick();
    chk("pre_done", 32'(done), 32'd0);
    tick();
    chk("step7_done", 32'(done), 32'd1);
    chk("step7_busy", 32'(busy), 32'd0);
    chk("step7_in3", 32'(in3), 32'hFF);
    chk("step7_in0", 32'(in0), 32'hFF);
    tick();
    chk("done_once", 32'(done), 32'd0);

    // Fill past capacity, then clear
    clr = 1'b1; tick(); clr = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wr_data = 8'(8'h10 + i);
      tick();
    end
    wr_en = 1'b0;
    chk("full_len", 32'(len), 32'd8);
    chk("full_flag", 32'(full), 32'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_len", 32'(len), 32'd0);
    chk("clr_in0", 32'(in0), 32'hFF);

    // Two-entry looping scroll: 18 steps, pattern period 6 steps
    wr_en = 1'b1;
    wr_data = 8'h11; tick();
    wr_data = 8'h22; tick();
    wr_en = 1'b0;
    loop = 1'b1; start = 1'b1; tick(); start = 1'b0;
    repeat (8) tick();
    chk("loop_p1_in1", 32'(in1), 32'h11);
    chk("loop_p1_in0", 32'(in0), 32'h22);
    repeat (24) tick();
    chk("loop_p2_in1", 32'(in1), 32'h11);
    chk("loop_p2_in0", 32'(in0), 32'h22);
    repeat (40) tick();
    chk("loop_busy", 32'(busy), 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_len", 32'(len), 32'd2);
    repeat (2) tick();

    // stop on the step cycle suppresses the shift
    loop = 1'b0; start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_step_in0", 32'(in0), 32'hFF);
    chk("stop_step_busy", 32'(busy), 32'd0);

    // Writes while busy are dropped
    start = 1'b1; tick(); start = 1'b0;
    wr_en = 1'b1; wr_data = 8'h55; tick(); wr_en = 1'b0;
    chk("busy_wr_len", 32'(len), 32'd2);
    stop = 1'b1; tick(); stop = 1'b0;

    // Same-cycle write and start from an empty buffer
    clr = 1'b1; tick(); clr = 1'b0;
    wr_en = 1'b1; wr_data = 8'h77; start = 1'b1; tick();
    wr_en = 1'b0; start = 1'b0;
    chk("wr_start_busy", 32'(busy), 32'd1);
    chk("wr_start_len", 32'(len), 32'd1);
    repeat (4) tick();
    chk("wr_start_in0", 32'(in0), 32'h77);
    repeat (20) tick();

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      reset   = ($urandom_range(0, 299) == 0);
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_data = 8'($urandom);
      clr     = ($urandom_range(0, 39) == 0);
      start   = ($urandom_range(0, 7) == 0);
      stop    = ($urandom_range(0, 79) == 0);
      loop    = ($urandom_range(0, 1) == 1);
      tick();
    end
    reset = 1'b0;
    idle_in();
    tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
